// File: rtl/id_ex_stage_pkg.sv
// Shared decode-control definitions for the ID/EX boundary and the control unit.
// Combinational definitions only; no latency or backpressure.
// Provides the ALU op encodings and the packed control bundle.
package id_ex_stage_pkg;

    localparam logic [1:0] ALU_OP_ADD   = 2'd0;
    localparam logic [1:0] ALU_OP_SUB   = 2'd1;
    localparam logic [1:0] ALU_OP_RTYPE = 2'd2;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       branch;
        logic       mem_read;
        logic       mem_2_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       jump;
    } ctrl_t;

    // A bubble is an all-zero bundle: it never writes registers or memory.
    function automatic ctrl_t ctrl_bubble();
        ctrl_t c;
        c        = '0;
        c.alu_op = ALU_OP_ADD;
        return c;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the decode instruction and a load sitting in EX.
// Latency: purely combinational.
// Backpressure: stall_o holds PC and IF/ID; suppressed when the decode instruction is flushed.
module hazard_detect #(
    parameter int RADDR_W = 5
) (
    input  logic [RADDR_W-1:0] id_rs,
    input  logic [RADDR_W-1:0] id_rt,
    input  logic               rs_used,
    input  logic               rt_used,
    input  logic               ex_valid,
    input  logic               ex_mem_read,
    input  logic [RADDR_W-1:0] ex_rt,
    input  logic               flush_i,
    output logic               haz,
    output logic               stall_o
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit  = rs_used && (id_rs == ex_rt);
    assign rt_hit  = rt_used && (id_rt == ex_rt);
    // $0 is hard-wired, so a load targeting it can never create a dependency.
    assign haz     = ex_valid && ex_mem_read && (ex_rt != '0) && (rs_hit || rt_hit);
    assign stall_o = haz && !flush_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush squash and saturating event counters.
// Latency: 1 cycle from id_* to ex_*; stall_o is combinational from id_* and registered ex_*.
// Backpressure: on a load-use hazard stall_o holds upstream for one cycle while a bubble enters EX.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               flush_i,
    input  logic [1:0]         id_alu_op,
    input  logic               id_reg_dst,
    input  logic               id_branch,
    input  logic               id_mem_read,
    input  logic               id_mem_2_reg,
    input  logic               id_mem_write,
    input  logic               id_alu_src,
    input  logic               id_reg_write,
    input  logic               id_jump,
    input  logic [RADDR_W-1:0] id_rs,
    input  logic [RADDR_W-1:0] id_rt,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic [DATA_W-1:0]  id_rdata1,
    input  logic [DATA_W-1:0]  id_rdata2,
    input  logic [DATA_W-1:0]  id_imm_ext,
    input  logic [DATA_W-1:0]  id_pc_plus4,
    input  logic [5:0]         id_funct,
    output logic               stall_o,
    output logic [1:0]         ex_alu_op,
    output logic               ex_reg_dst,
    output logic               ex_branch,
    output logic               ex_mem_read,
    output logic               ex_mem_2_reg,
    output logic               ex_mem_write,
    output logic               ex_alu_src,
    output logic               ex_reg_write,
    output logic               ex_jump,
    output logic [RADDR_W-1:0] ex_rs,
    output logic [RADDR_W-1:0] ex_rt,
    output logic [RADDR_W-1:0] ex_rd,
    output logic [DATA_W-1:0]  ex_rdata1,
    output logic [DATA_W-1:0]  ex_rdata2,
    output logic [DATA_W-1:0]  ex_imm_ext,
    output logic [DATA_W-1:0]  ex_pc_plus4,
    output logic [5:0]         ex_funct,
    output logic               ex_valid,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    ctrl_t id_ctrl;
    ctrl_t ex_ctrl;
    logic  rs_used;
    logic  rt_used;
    logic  haz;

    assign id_ctrl = '{alu_op:    id_alu_op,
                       reg_dst:   id_reg_dst,
                       branch:    id_branch,
                       mem_read:  id_mem_read,
                       mem_2_reg: id_mem_2_reg,
                       mem_write: id_mem_write,
                       alu_src:   id_alu_src,
                       reg_write: id_reg_write,
                       jump:      id_jump};

    // rt is a source only for R-type, branches and stores; otherwise it is the destination.
    assign rs_used = !id_jump;
    assign rt_used = id_reg_dst || id_branch || id_mem_write;

    hazard_detect #(
        .RADDR_W (RADDR_W)
    ) u_hazard_detect (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .rs_used     (rs_used),
        .rt_used     (rt_used),
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_ctrl.mem_read),
        .ex_rt       (ex_rt),
        .flush_i     (flush_i),
        .haz         (haz),
        .stall_o     (stall_o)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ex_ctrl     <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
            ex_rdata1   <= '0;
            ex_rdata2   <= '0;
            ex_imm_ext  <= '0;
            ex_pc_plus4 <= '0;
            ex_funct    <= '0;
            ex_valid    <= 1'b0;
        end else if (flush_i || haz) begin
            ex_ctrl     <= ctrl_bubble();
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
            ex_rdata1   <= '0;
            ex_rdata2   <= '0;
            ex_imm_ext  <= '0;
            ex_pc_plus4 <= '0;
            ex_funct    <= '0;
            ex_valid    <= 1'b0;
        end else begin
            ex_ctrl     <= id_ctrl;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_rd       <= id_rd;
            ex_rdata1   <= id_rdata1;
            ex_rdata2   <= id_rdata2;
            ex_imm_ext  <= id_imm_ext;
            ex_pc_plus4 <= id_pc_plus4;
            ex_funct    <= id_funct;
            ex_valid    <= 1'b1;
        end
    end

    // Flush outranks a stall, so a squashed hazard counts only as a flush.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (flush_i) begin
            if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
        end else if (haz) begin
            if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign ex_alu_op    = ex_ctrl.alu_op;
    assign ex_reg_dst   = ex_ctrl.reg_dst;
    assign ex_branch    = ex_ctrl.branch;
    assign ex_mem_read  = ex_ctrl.mem_read;
    assign ex_mem_2_reg = ex_ctrl.mem_2_reg;
    assign ex_mem_write = ex_ctrl.mem_write;
    assign ex_alu_src   = ex_ctrl.alu_src;
    assign ex_reg_write = ex_ctrl.reg_write;
    assign ex_jump      = ex_ctrl.jump;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: pass-through, load-use stalls, false-hazard cases,
// flush priority, asynchronous reset and counter saturation.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam int DATA_W  = 32;
    localparam int RADDR_W = 5;
    localparam int CNT_W   = 8;
    localparam int BUS_W   = 10 + 3*RADDR_W + 4*DATA_W + 6;

    typedef struct packed {
        logic               flush;
        ctrl_t              ctrl;
        logic [RADDR_W-1:0] rs;
        logic [RADDR_W-1:0] rt;
        logic [RADDR_W-1:0] rd;
        logic [DATA_W-1:0]  rdata1;
        logic [DATA_W-1:0]  rdata2;
        logic [DATA_W-1:0]  imm;
        logic [DATA_W-1:0]  pc4;
        logic [5:0]         funct;
    } id_in_t;

    typedef struct {
        id_in_t           in;
        logic             exp_stall;
        logic             exp_load;
        logic [CNT_W-1:0] exp_scnt;
        logic [CNT_W-1:0] exp_fcnt;
    } vec_t;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    id_in_t cur = '0;
    int checks = 0;
    int errors = 0;

    logic               stall_o, ex_valid;
    logic [1:0]         ex_alu_op;
    logic               ex_reg_dst, ex_branch, ex_mem_read, ex_mem_2_reg;
    logic               ex_mem_write, ex_alu_src, ex_reg_write, ex_jump;
    logic [RADDR_W-1:0] ex_rs, ex_rt, ex_rd;
    logic [DATA_W-1:0]  ex_rdata1, ex_rdata2, ex_imm_ext, ex_pc_plus4;
    logic [5:0]         ex_funct;
    logic [CNT_W-1:0]   stall_cnt, flush_cnt;
    logic [BUS_W-1:0]   ex_bus;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .flush_i      (cur.flush),
        .id_alu_op    (cur.ctrl.alu_op),
        .id_reg_dst   (cur.ctrl.reg_dst),
        .id_branch    (cur.ctrl.branch),
        .id_mem_read  (cur.ctrl.mem_read),
        .id_mem_2_reg (cur.ctrl.mem_2_reg),
        .id_mem_write (cur.ctrl.mem_write),
        .id_alu_src   (cur.ctrl.alu_src),
        .id_reg_write (cur.ctrl.reg_write),
        .id_jump      (cur.ctrl.jump),
        .id_rs        (cur.rs),
        .id_rt        (cur.rt),
        .id_rd        (cur.rd),
        .id_rdata1    (cur.rdata1),
        .id_rdata2    (cur.rdata2),
        .id_imm_ext   (cur.imm),
        .id_pc_plus4  (cur.pc4),
        .id_funct     (cur.funct),
        .stall_o      (stall_o),
        .ex_alu_op    (ex_alu_op),
        .ex_reg_dst   (ex_reg_dst),
        .ex_branch    (ex_branch),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_2_reg (ex_mem_2_reg),
        .ex_mem_write (ex_mem_write),
        .ex_alu_src   (ex_alu_src),
        .ex_reg_write (ex_reg_write),
        .ex_jump      (ex_jump),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .ex_rd        (ex_rd),
        .ex_rdata1    (ex_rdata1),
        .ex_rdata2    (ex_rdata2),
        .ex_imm_ext   (ex_imm_ext),
        .ex_pc_plus4  (ex_pc_plus4),
        .ex_funct     (ex_funct),
        .ex_valid     (ex_valid),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    assign ex_bus = {ex_alu_op, ex_reg_dst, ex_branch, ex_mem_read, ex_mem_2_reg,
                     ex_mem_write, ex_alu_src, ex_reg_write, ex_jump,
                     ex_rs, ex_rt, ex_rd, ex_rdata1, ex_rdata2, ex_imm_ext,
                     ex_pc_plus4, ex_funct};

    task automatic chk(input string name, input logic [BUS_W-1:0] act,
                       input logic [BUS_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic ctrl_t mk_ctrl(input logic [1:0] alu, input logic rdst, input logic br,
                                      input logic mr, input logic m2r, input logic mw,
                                      input logic asrc, input logic rw, input logic j);
        ctrl_t c;
        c = '{alu_op: alu, reg_dst: rdst, branch: br, mem_read: mr, mem_2_reg: m2r,
              mem_write: mw, alu_src: asrc, reg_write: rw, jump: j};
        return c;
    endfunction

    function automatic id_in_t mk_in(input logic fl, input ctrl_t c, input int rs, input int rt,
                                     input int rd, input int seed);
        id_in_t v;
        v.flush  = fl;
        v.ctrl   = c;
        v.rs     = RADDR_W'(rs);
        v.rt     = RADDR_W'(rt);
        v.rd     = RADDR_W'(rd);
        v.rdata1 = 32'hA000_0000 + 32'(seed);
        v.rdata2 = 32'hB000_0000 + 32'(seed);
        v.imm    = 32'hFFFF_FF00 + 32'(seed);
        v.pc4    = 32'h0040_0000 + 32'(seed * 4);
        v.funct  = 6'(seed + 6'h20);
        return v;
    endfunction

    function automatic logic [BUS_W-1:0] in_bus(input id_in_t v);
        return {v.ctrl, v.rs, v.rt, v.rd, v.rdata1, v.rdata2, v.imm, v.pc4, v.funct};
    endfunction

    vec_t vecs[17];

    initial begin
        ctrl_t c_add, c_lw, c_addi, c_j, c_sw, c_beq;
        c_add  = mk_ctrl(ALU_OP_RTYPE, 1, 0, 0, 0, 0, 0, 1, 0);
        c_lw   = mk_ctrl(ALU_OP_ADD,   0, 0, 1, 1, 0, 1, 1, 0);
        c_addi = mk_ctrl(ALU_OP_ADD,   0, 0, 0, 0, 0, 1, 1, 0);
        c_j    = mk_ctrl(ALU_OP_ADD,   0, 0, 0, 0, 0, 0, 0, 1);
        c_sw   = mk_ctrl(ALU_OP_ADD,   0, 0, 0, 0, 1, 1, 0, 0);
        c_beq  = mk_ctrl(ALU_OP_SUB,   0, 1, 0, 0, 0, 0, 0, 0);

        //            input                              stall load scnt fcnt
        vecs[0]  = '{mk_in(0, c_add,  1, 2, 3,  1),  0, 1, 0, 0};
        vecs[1]  = '{mk_in(0, c_lw,   1, 5, 0,  2),  0, 1, 0, 0};
        vecs[2]  = '{mk_in(0, c_add,  5, 6, 7,  3),  1, 0, 1, 0};
        vecs[3]  = '{mk_in(0, c_add,  5, 6, 7,  3),  0, 1, 1, 0};
        vecs[4]  = '{mk_in(0, c_lw,   2, 0, 0,  4),  0, 1, 1, 0};
        vecs[5]  = '{mk_in(0, c_add,  0, 0, 8,  5),  0, 1, 1, 0};
        vecs[6]  = '{mk_in(0, c_lw,   3, 5, 0,  6),  0, 1, 1, 0};
        vecs[7]  = '{mk_in(0, c_addi, 4, 5, 0,  7),  0, 1, 1, 0};
        vecs[8]  = '{mk_in(0, c_lw,   3, 5, 0,  8),  0, 1, 1, 0};
        vecs[9]  = '{mk_in(0, c_j,    5, 5, 0,  9),  0, 1, 1, 0};
        vecs[10] = '{mk_in(0, c_lw,   1, 5, 0, 10),  0, 1, 1, 0};
        vecs[11] = '{mk_in(0, c_sw,   2, 5, 0, 11),  1, 0, 2, 0};
        vecs[12] = '{mk_in(0, c_sw,   2, 5, 0, 11),  0, 1, 2, 0};
        vecs[13] = '{mk_in(0, c_lw,   1, 5, 0, 13),  0, 1, 2, 0};
        vecs[14] = '{mk_in(1, c_beq,  5, 9, 0, 14),  0, 0, 2, 1};
        vecs[15] = '{mk_in(0, c_add,  1, 2, 3, 15),  0, 1, 2, 1};
        vecs[16] = '{mk_in(1, c_add,  1, 2, 3, 16),  0, 0, 2, 2};

        // Reset state before any clock edge.
        #3;
        chk("reset_bus",   BUS_W'(ex_bus),   '0);
        chk("reset_valid", BUS_W'(ex_valid), '0);
        chk("reset_cnt",   BUS_W'({stall_cnt, flush_cnt}), '0);
        @(negedge clk);
        arst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            cur = vecs[i].in;
            #1;
            chk($sformatf("v%0d_stall", i), BUS_W'(stall_o), BUS_W'(vecs[i].exp_stall));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ex", i), ex_bus, vecs[i].exp_load ? in_bus(vecs[i].in) : '0);
            chk($sformatf("v%0d_valid", i), BUS_W'(ex_valid), BUS_W'(vecs[i].exp_load));
            chk($sformatf("v%0d_cnt", i), BUS_W'({stall_cnt, flush_cnt}),
                BUS_W'({vecs[i].exp_scnt, vecs[i].exp_fcnt}));
        end

        // Load a valid instruction, then assert reset mid-cycle with no clock edge.
        @(negedge clk);
        cur = vecs[0].in;
        @(posedge clk);
        #1;
        chk("pre_arst_valid", BUS_W'(ex_valid), BUS_W'(1));
        #2;
        arst_n = 1'b0;
        #1;
        chk("arst_bus",   ex_bus, '0);
        chk("arst_valid", BUS_W'(ex_valid), '0);
        chk("arst_cnt",   BUS_W'({stall_cnt, flush_cnt}), '0);
        @(negedge clk);
        arst_n = 1'b1;

        // Saturation: 2^CNT_W + 3 consecutive flushes.
        cur = mk_in(1, c_add, 1, 2, 3, 20);
        for (int i = 0; i < (1 << CNT_W) - 1; i++) @(posedge clk);
        #1;
        chk("sat_reach_max", BUS_W'(flush_cnt), BUS_W'({CNT_W{1'b1}}));
        for (int i = 0; i < 4; i++) @(posedge clk);
        #1;
        chk("sat_hold_max", BUS_W'(flush_cnt), BUS_W'({CNT_W{1'b1}}));
        chk("sat_stall_cnt", BUS_W'(stall_cnt), '0);
        chk("sat_valid", BUS_W'(ex_valid), '0);
        @(negedge clk);
        cur = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
